// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute/memory requesters, decode hazard checks
// and the register file write port.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic [4:0]            req0_rd;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [4:0]            req1_rd;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  rf_we;
  logic [4:0]            rf_rd;
  logic [DATA_WIDTH-1:0] rf_data;
  logic                  iss_valid;
  logic [4:0]            iss_rd;
  logic [4:0]            chk_rs;
  logic [4:0]            chk_rt;
  logic                  hazard_rs;
  logic                  hazard_rt;
  logic                  err_unexpected;

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    input  iss_valid, iss_rd, chk_rs, chk_rt,
    output req0_ready, req1_ready,
    output rf_we, rf_rd, rf_data,
    output hazard_rs, hazard_rt, err_unexpected
  );

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    output iss_valid, iss_rd, chk_rs, chk_rt,
    input  req0_ready, req1_ready,
    input  rf_we, rf_rd, rf_data,
    input  hazard_rs, hazard_rt, err_unexpected
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port, with a pending-write
// scoreboard that flags RAW hazards for decode.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned NR = NUM_REGS;

  // ptr_q=1 means req1 holds priority on the next contended cycle
  logic                  ptr_q, ptr_d;
  logic                  rf_we_q, rf_we_d;
  logic [4:0]            rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic                  err_q, err_d;

  logic                  gnt0, gnt1, xfer, xfer_ok, iss_ok;
  logic [4:0]            xfer_rd;
  logic [DATA_WIDTH-1:0] xfer_data;
  logic                  haz_rs, haz_rt;

  function automatic logic rd_ok(input logic [4:0] rd);
    return (rd != 5'd0) && ({27'd0, rd} < NR);
  endfunction

  always_comb begin
    gnt0      = !rst && bus.req0_valid && (!bus.req1_valid || !ptr_q);
    gnt1      = !rst && bus.req1_valid && (!bus.req0_valid || ptr_q);
    xfer      = gnt0 || gnt1;
    xfer_rd   = gnt0 ? bus.req0_rd   : bus.req1_rd;
    xfer_data = gnt0 ? bus.req0_data : bus.req1_data;
    xfer_ok   = xfer && rd_ok(xfer_rd);
    iss_ok    = bus.iss_valid && rd_ok(bus.iss_rd);

    ptr_d = ptr_q;
    if (gnt0) ptr_d = 1'b1;
    if (gnt1) ptr_d = 1'b0;

    rf_we_d   = xfer_ok;
    rf_rd_d   = xfer_ok ? xfer_rd   : rf_rd_q;
    rf_data_d = xfer_ok ? xfer_data : rf_data_q;

    // A same-cycle issue to the retiring register is a newer producer, so set wins
    pending_d = pending_q;
    err_d     = err_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (xfer_ok && xfer_rd == 5'(i) && !(iss_ok && bus.iss_rd == 5'(i))) begin
        if (!pending_q[i]) err_d = 1'b1;
        pending_d[i] = 1'b0;
      end
      if (iss_ok && bus.iss_rd == 5'(i)) pending_d[i] = 1'b1;
    end
  end

  always_comb begin
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (bus.chk_rs == 5'(i)) haz_rs = pending_q[i];
      if (bus.chk_rt == 5'(i)) haz_rt = pending_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign bus.req0_ready     = gnt0;
  assign bus.req1_ready     = gnt1;
  assign bus.rf_we          = rf_we_q;
  assign bus.rf_rd          = rf_rd_q;
  assign bus.rf_data        = rf_data_q;
  assign bus.hazard_rs      = haz_rs;
  assign bus.hazard_rt      = haz_rt;
  assign bus.err_unexpected = err_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of the writeback arbiter against a behavioural
// model of grants, register-file writes and the pending-register set.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_WIDTH(DW)) bus ();
  regfile_wb_arbiter #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // model: set of registers awaiting a write, last winner, expected rf outputs
  bit          m_pend[NR];
  int          m_last;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_known;
  bit          m_err;
  bit          m_init = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [4:0] r);
    return (r != 5'd0) && (int'(r) < NR);
  endfunction

  function automatic bit m_haz(input logic [4:0] r);
    if (!in_range(r)) return 1'b0;
    return m_pend[int'(r)];
  endfunction

  task automatic cyc(input bit r,
                     input bit v0, input logic [4:0] rd0, input logic [31:0] d0,
                     input bit v1, input logic [4:0] rd1, input logic [31:0] d1,
                     input bit iv, input logic [4:0] ird,
                     input logic [4:0] rs, input logic [4:0] rt);
    bit g0, g1, xfer, sset;
    logic [4:0] xrd;
    logic [31:0] xd;
    rst = r;
    bus.req0_valid = v0; bus.req0_rd = rd0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_rd = rd1; bus.req1_data = d1;
    bus.iss_valid = iv; bus.iss_rd = ird;
    bus.chk_rs = rs; bus.chk_rt = rt;
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (!r) begin
      if (v0 && v1) begin
        if (m_last == 0) g1 = 1'b1; else g0 = 1'b1;
      end else if (v0) g0 = 1'b1;
      else if (v1) g1 = 1'b1;
    end
    chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
    if (m_init) begin
      chk("hazard_rs", 32'(bus.hazard_rs), 32'(m_haz(rs)));
      chk("hazard_rt", 32'(bus.hazard_rt), 32'(m_haz(rt)));
    end
    @(posedge clk);
    if (r) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_last = 1; m_we = 1'b0; m_rd = '0; m_data = '0;
      m_known = 1'b1; m_err = 1'b0; m_init = 1'b1;
    end else begin
      xfer = g0 || g1;
      xrd  = g0 ? rd0 : rd1;
      xd   = g0 ? d0 : d1;
      sset = iv && in_range(ird);
      m_we = xfer && in_range(xrd);
      if (m_we) begin
        m_rd = xrd; m_data = xd; m_known = 1'b1;
      end else if (xfer) m_known = 1'b0;
      if (m_we && !(sset && ird == xrd)) begin
        if (!m_pend[int'(xrd)]) m_err = 1'b1;
        m_pend[int'(xrd)] = 1'b0;
      end
      if (sset) m_pend[int'(ird)] = 1'b1;
      if (g0) m_last = 0;
      if (g1) m_last = 1;
    end
    #1;
    if (m_init) begin
      chk("rf_we", 32'(bus.rf_we), 32'(m_we));
      if (m_known) begin
        chk("rf_rd", 32'(bus.rf_rd), 32'(m_rd));
        chk("rf_data", bus.rf_data, m_data);
      end
      chk("err_unexpected", 32'(bus.err_unexpected), 32'(m_err));
    end
  endtask

  task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, rs, rt);
  endtask

  initial begin
    // reset then idle
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 5'd2, 32'h11, 1, 5'd3, 32'h22, 0, 0, 5, 3);
    idle(5, 3);
    idle(1, 15);

    // single write with hazard visible until the cycle after the transfer
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 5, 0);
    cyc(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5);
    idle(5, 5);

    // filtered indices still handshake but never write
    cyc(0, 0, 0, 0, 1, 5'd0, 32'h1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 5'd20, 32'h2, 0, 0, 20, 16);
    idle(0, 20);

    // contention: req0 wins first, then req1
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 3, 4);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 3, 4);
    cyc(0, 1, 5'd3, 32'hA3A3A3A3, 1, 5'd4, 32'hB4B4B4B4, 0, 0, 3, 4);
    cyc(0, 1, 5'd3, 32'hA3A3A3A3, 1, 5'd4, 32'hB4B4B4B4, 1, 5'd3, 3, 4);
    cyc(0, 1, 5'd3, 32'hC3C3C3C3, 0, 0, 0, 0, 0, 3, 4);
    idle(3, 4);

    // set/clear collision on r7
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 7, 7);
    cyc(0, 1, 5'd7, 32'h77, 0, 0, 0, 1, 5'd7, 7, 7);
    idle(7, 7);
    cyc(0, 0, 0, 0, 1, 5'd7, 32'h78, 0, 0, 7, 7);
    idle(7, 7);

    // unexpected write, sticky error, then reset mid-transfer
    cyc(0, 1, 5'd9, 32'h99, 0, 0, 0, 0, 0, 9, 9);
    idle(9, 9);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 5'd11, 11, 9);
    cyc(1, 0, 0, 0, 1, 5'd11, 32'hBB, 0, 0, 11, 9);
    for (int i = 0; i < 32; i += 2) idle(5'(i), 5'(i + 1));

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 59) == 0),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: req0 (ALU result) and req1 (load/memory result).
- Tracks outstanding destination registers in a scoreboard so that decode can detect read-after-write hazards on rs/rt.
- Sits between the execute/memory stages and the register file. It drives the file's we/rd/data inputs from a registered output stage.

Parameters:
- DATA_WIDTH, 32, width of writeback data.
- NUM_REGS, 16, number of implemented registers; indices >= NUM_REGS are unimplemented.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  ALU writeback request
- req0_rd  input  5  ALU destination register
- req0_data  input  DATA_WIDTH  ALU writeback data
- req0_ready  output  1  grant to req0; a transfer occurs when valid&&ready
- req1_valid  input  1  memory writeback request
- req1_rd  input  5  memory destination register
- req1_data  input  DATA_WIDTH  memory writeback data
- req1_ready  output  1  grant to req1
- rf_we  output  1  register file write enable (registered)
- rf_rd  output  5  register file write index (registered)
- rf_data  output  DATA_WIDTH  register file write data (registered)
- iss_valid  input  1  decode issued an instruction with a destination
- iss_rd  input  5  destination register of the issued instruction
- chk_rs  input  5  decode source register rs
- chk_rt  input  5  decode source register rt
- hazard_rs  output  1  rs has a pending write (combinational)
- hazard_rt  output  1  rt has a pending write (combinational)
- err_unexpected  output  1  sticky flag: writeback to a non-pending register

Behaviour:
- Reset: synchronous, active-high (rst); clock clk. On rst all of the following are cleared:
  - rf_we=0, rf_rd=0, rf_data=0.
  - pending[NUM_REGS-1:0]=0.
  - err_unexpected=0.
  - Round-robin pointer set so that req0 has priority.
- While rst is high, req0_ready=0 and req1_ready=0.
- Reset mid-operation: a request accepted in the rst cycle is discarded. rf_we=0 in the cycle after rst.
- Arbitration (combinational ready):
  - At most one grant per cycle.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not granted most recently.
  - The pointer updates only on a transfer.
  - The arbiter never stalls a lone requester. There is no backpressure from the register file.
- Ready depends only on the valids and the pointer, never on ready itself (no combinational loop).
- Write stage, one cycle latency:
  - A transfer in cycle N yields rf_we=1, rf_rd=rd, rf_data=data in cycle N+1.
  - No transfer in cycle N gives rf_we=0 in N+1; rf_rd and rf_data hold their previous values.
  - The register file captures the write on the following negedge.
- Index filter: if rd==0 or rd>=NUM_REGS, the handshake still completes, but rf_we stays 0 in N+1 and pending is untouched.
- Scoreboard:
  - iss_valid with 0<iss_rd<NUM_REGS sets pending[iss_rd] at the clock edge. Other iss_rd values are ignored.
  - A transfer with a valid rd clears pending[rd] at the same edge.
  - Same register set and cleared in the same cycle: set wins, since it is a newer producer.
  - Transfer to a valid rd whose pending bit is 0 (and not being set that cycle): err_unexpected goes to 1 and stays set until rst.
- Hazard outputs:
  - hazard_rs = pending[chk_rs] when 0<chk_rs<NUM_REGS, else 0. hazard_rt is the same on chk_rt.
  - They reflect registered pending state, so a clear is visible in the cycle after the transfer.
  - Decode must still stall in the transfer cycle.
- Width: data is passed unmodified; rd is 5 bits and is compared against NUM_REGS unsigned.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all valids low → rf_we=0, rf_rd=0, rf_data=0, hazard_rs=hazard_rt=0, both ready=0 during rst, err_unexpected=0.
- Single write: iss rd=5; next cycle req0 valid rd=5 data=0xDEADBEEF → req0_ready=1 the same cycle; next cycle rf_we=1, rf_rd=5, rf_data=0xDEADBEEF; hazard_rs (chk_rs=5) is 1 before the transfer and 0 the cycle after.
- Contention: iss rd 3 and rd 4; then req0 rd=3 and req1 rd=4 both valid for 2 cycles → cycle 1 grants req0, cycle 2 grants req1; rf writes appear as 3 then 4 on consecutive cycles; no double grant.
- Filter: req1 valid rd=0 data=0x1, then rd=20 → each handshake completes, rf_we stays 0, pending unchanged, err_unexpected stays 0.
- Set/clear collision: pending[7]=1; in one cycle iss rd=7 and req0 transfer rd=7 → pending[7] stays 1, hazard on chk_rs=7 stays 1, no error.
- Unexpected plus mid-op reset: req0 rd=9 with pending[9]=0 → err_unexpected=1 next cycle and sticky; then req1 transfer coincident with rst=1 → rf_we=0 next cycle, err_unexpected=0, pending all 0.
